pc_fetch_unit: RTL
==================

# pc_fetch_unit

Fetch-stage PC generator feeding the 2-bit branch predictor and consuming its `prediction` output. It fetches one instruction per cycle and steers the PC down the predicted path when the fetched instruction is a conditional branch (`instr[31:28] == 4'b0111`). It holds each unresolved branch in a small in-order queue. When the execute stage resolves a branch, it recovers from mispredictions by redirecting the PC and flushing.

## Interface
- `PC_W`, 32: PC width in bits.
- `QDEPTH`, 4: in-flight branch queue depth, a power of two, at least 2.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) immediately clears all state.
- `stall`  in  1  downstream hold; when 1, the PC and queue push are frozen. Resolve is still processed.
- `instr`  in  32  instruction at the current `pc`, combinational from imem.
- `prediction`  in  1  predictor output for the current branch: 1 = taken.
- `resolve_valid`  in  1  execute stage resolves the oldest queued branch this cycle.
- `resolve_taken`  in  1  actual outcome; this is the predictor's `pc_mux_sel`.
- `pc`  out  PC_W  current fetch address, registered.
- `fetch_valid`  out  1  the instruction at `pc` is accepted this cycle.
- `flush`  out  1  registered one-cycle pulse after a misprediction.
- `queue_full`  out  1  the branch queue holds QDEPTH entries.
- `resolve_err`  out  1  sticky; set when a resolve arrives while the queue is empty.
- `mispredict_cnt`  out  16  misprediction counter (see Configuration).

## Operation
Branch detection and address arithmetic:
- `is_branch = (instr[31:28] == 4'b0111)`.
- `seq = pc + 4`.
- `target = seq + (sign_extend(instr[15:0]) << 2)`.
- All arithmetic is modulo 2^PC_W; PC wrap-around is silent.

Queue entries hold `{pred, alt_pc}`, in FIFO order, with an occupancy count of 0..QDEPTH.

Per-cycle priority, highest first:
1. **Mispredict.**
   - Condition: `resolve_valid && count != 0 && resolve_taken != head.pred`.
   - Next `pc = head.alt_pc` and the queue empties.
   - The fetch in the current cycle is discarded and nothing is pushed, even if it is a branch.
   - `flush` is 1 in the next cycle; the mispredict counter increments.
2. **Correct resolve.**
   - Condition: `resolve_valid && count != 0` with a matching outcome.
   - Pop the head. It may coincide with the push below; net count is unchanged on push+pop.
3. **Fetch accept.**
   - `fetch_valid = !stall && !(is_branch && full) && !mispredict`.
   - Branch accept: push `{prediction, prediction ? seq : target}`; next `pc = prediction ? target : seq`.
   - Non-branch accept: next `pc = seq`.
4. **Hold.** Otherwise `pc` is unchanged.

Additional rules:
- Resolve with an empty queue: ignored, and `resolve_err` is set until reset.
- A full queue and a branch at `pc` with a simultaneous correct resolve: the push still stalls this cycle and is accepted the next cycle. `fetch_valid` uses the registered count.
- Reset mid-operation: the queue is discarded, `pc = RESET_PC`, and no flush pulse is generated.

## Timing
- Reset values: `pc = RESET_PC`, count 0, `flush = 0`, `queue_full = 0`, `resolve_err = 0`, `mispredict_cnt = 0`.
- `pc` updates one cycle after the accept; a redirect after a mispredict is visible the cycle after `resolve_valid`, coincident with `flush = 1`.
- `fetch_valid` is combinational from `stall`, `instr`, the registered count, and the resolve inputs.
- `queue_full` and `flush` are registered.
- `prediction` must be valid in the same cycle as `instr`.

## Configuration
- `MISPREDICT_CNT_EN` defined: `mispredict_cnt` is a 16-bit counter that saturates at 16'hFFFF, increments once per mispredict, and is cleared only by reset.
- Not defined: no counter flops exist and `mispredict_cnt` is tied to 16'h0000.

## Test plan
- **Sequential fetch.** Release reset with non-branch `instr` and `stall = 0` -> `pc` steps 0, 4, 8, 12; `fetch_valid = 1`; `flush` stays 0.
- **Predicted-taken branch.** At `pc = 0x10`, `instr = 0x7000_0004`, `prediction = 1` -> next `pc = 0x24`. Resolve with `resolve_taken = 1` -> no flush, queue empties.
- **Mispredict.** Same branch with `prediction = 1`, then resolve with `resolve_taken = 0` -> next cycle `pc = 0x14`, `flush = 1` for exactly one cycle; `mispredict_cnt = 1` when the macro is defined, else 0.
- **Queue full.** Four unresolved branches, then a fifth branch at `pc` -> `queue_full = 1`, `fetch_valid = 0`, `pc` held. A correct resolve that cycle -> the fifth branch is accepted the next cycle.
- **Error and stall.** `resolve_valid` with an empty queue -> `resolve_err` goes high and stays high. `stall = 1` -> `pc` frozen while a mispredict still redirects.
- **Async reset.** Drop `reset` to 0 mid-cycle with the queue at count 3 -> `pc = RESET_PC` immediately; after release, count is 0 and `flush` is 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC generator with an in-order queue of unresolved
// branches. It steers the PC down the predicted path and recovers from
// mispredictions by redirecting to the queued alternate PC and flushing.
// Optional feature macro: MISPREDICT_CNT_EN (saturating 16-bit mispredict counter).
module pc_fetch_unit #(
    parameter int unsigned    PC_W     = 32,
    parameter int unsigned    QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [31:0]     instr,
    input  logic            prediction,
    input  logic            resolve_valid,
    input  logic            resolve_taken,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            flush,
    output logic            queue_full,
    output logic            resolve_err,
    output logic [15:0]     mispredict_cnt
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             flush_q, flush_d;
    logic             full_q, full_d;
    logic             err_q, err_d;
    logic             pred_q [QDEPTH];
    logic [PC_W-1:0]  alt_q  [QDEPTH];

    logic             is_branch;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  imm_sext;
    logic [PC_W-1:0]  target_pc;
    logic             q_empty;
    logic             q_full;
    logic             mispredict;
    logic             pop;
    logic             push;
    logic             unused_instr;

    // Decode and address arithmetic for the instruction at the current PC
    always_comb begin
        is_branch = (instr[31:28] == 4'b0111);
        seq_pc    = pc_q + PC_W'(4);
        imm_sext  = PC_W'($signed(instr[15:0]));
        target_pc = seq_pc + (imm_sext << 2);
    end

    assign unused_instr = ^instr[27:16];

    // Resolve/fetch arbitration; a mispredict discards the current fetch
    always_comb begin
        q_empty     = (count_q == '0);
        q_full      = (count_q == CNT_W'(QDEPTH));
        mispredict  = resolve_valid && !q_empty && (resolve_taken != pred_q[head_q]);
        pop         = resolve_valid && !q_empty && !mispredict;
        fetch_valid = !stall && !(is_branch && q_full) && !mispredict;
        push        = fetch_valid && is_branch;
    end

    // Next-state for PC, queue pointers, occupancy and status flags
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        flush_d = 1'b0;
        err_d   = err_q | (resolve_valid & q_empty);
        if (mispredict) begin
            pc_d    = alt_q[head_q];
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            flush_d = 1'b1;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (fetch_valid) begin
                pc_d = (is_branch && prediction) ? target_pc : seq_pc;
            end
        end
        full_d = (count_d == CNT_W'(QDEPTH));
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            flush_q <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            flush_q <= flush_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Branch queue storage: each entry holds the prediction and the other-path PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                pred_q[i] <= 1'b0;
                alt_q[i]  <= '0;
            end
        end else if (push) begin
            pred_q[tail_q] <= prediction;
            alt_q[tail_q]  <= prediction ? seq_pc : target_pc;
        end
    end

`ifdef MISPREDICT_CNT_EN
    logic [15:0] mcnt_q;

    // Saturating mispredict counter, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt_q <= 16'h0000;
        end else if (mispredict && (mcnt_q != 16'hFFFF)) begin
            mcnt_q <= mcnt_q + 16'd1;
        end
    end

    assign mispredict_cnt = mcnt_q;
`else
    assign mispredict_cnt = 16'h0000;
`endif

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign queue_full  = full_q;
    assign resolve_err = err_q;

endmodule
